// File: rtl/mem_arbiter_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_n
//  Purpose  : N-channel physical-memory arbiter, one outstanding transaction,
//             fixed-priority or round-robin grant with a release cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter_n #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter int RR_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req_read_i,
    input  logic [NUM_CH-1:0]          req_write_i,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_CH*LINE_W-1:0]   req_wdata_i,
    output logic [NUM_CH-1:0]          req_resp_o,
    output logic [LINE_W-1:0]          req_rdata_o,
    output logic                       pmem_read_o,
    output logic                       pmem_write_o,
    output logic [ADDR_W-1:0]          pmem_address_o,
    output logic [LINE_W-1:0]          pmem_wdata_o,
    input  logic                       pmem_resp_i,
    input  logic [LINE_W-1:0]          pmem_rdata_i,
    output logic [$clog2(NUM_CH)-1:0]  grant_id_o,
    output logic                       busy_o
);

    localparam int c_ID_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [c_ID_W-1:0]   grant_q, grant_d;

    logic [NUM_CH-1:0]   w_req;
    logic                w_any;
    logic [c_ID_W-1:0]   w_winner;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LINE_W-1:0]   w_sel_wdata;
    logic                w_sel_wr;

    assign w_req = req_read_i | req_write_i;
    assign w_any = |w_req;

    generate
        if (RR_MODE != 0) begin : g_rr
            logic [c_ID_W-1:0] last_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    last_q <= c_ID_W'(NUM_CH - 1);
                end else if (state_q == S_IDLE && w_any) begin
                    last_q <= w_winner;
                end
            end

            // Scan farthest-first so the nearest requester after last_q wins.
            always_comb begin
                int idx;
                idx      = 0;
                w_winner = '0;
                for (int k = NUM_CH; k >= 1; k--) begin
                    idx = int'(last_q) + k;
                    if (idx >= NUM_CH) idx = idx - NUM_CH;
                    if (w_req[idx]) w_winner = c_ID_W'(idx);
                end
            end
        end else begin : g_fixed
            always_comb begin
                w_winner = '0;
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (w_req[i]) w_winner = c_ID_W'(i);
                end
            end
        end
    endgenerate

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wr    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_winner == c_ID_W'(i)) begin
                w_sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata_i[i*LINE_W +: LINE_W];
                w_sel_wr    = req_write_i[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    state_d = S_BUSY;
                    grant_d = w_winner;
                    addr_d  = w_sel_addr;
                    wdata_d = w_sel_wdata;
                    wr_d    = w_sel_wr;
                    rd_d    = ~w_sel_wr;
                end
            end
            S_BUSY: begin
                if (pmem_resp_i) begin
                    state_d = S_RELEASE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
        end
    end

    // Completion strobe is combinational so the cache sees it in the pmem_resp cycle.
    always_comb begin
        req_resp_o = '0;
        if (state_q == S_BUSY && pmem_resp_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_q == c_ID_W'(i)) req_resp_o[i] = 1'b1;
            end
        end
    end

    assign req_rdata_o    = pmem_rdata_i;
    assign pmem_read_o    = rd_q;
    assign pmem_write_o   = wr_q;
    assign pmem_address_o = addr_q;
    assign pmem_wdata_o   = wdata_q;
    assign grant_id_o     = grant_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- Parametrised N-channel physical-memory arbiter; successor to the two-port I/D cache arbiter.
- Sits between N cache-side pmem masters and the single physical memory port.
- One transaction is outstanding at a time.
- Grants one channel, latches its address, write data and operation, then holds it until the memory responds.
- Adds selectable fixed-priority or round-robin arbitration, plus an explicit release cycle.

Parameters:
- NUM_CH, 2, number of requesting channels (must be >= 2).
- ADDR_W, 16, physical address width.
- LINE_W, 128, cache line width.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_read  input  NUM_CH  per-channel line read request; held until req_resp.
- req_write  input  NUM_CH  per-channel line write-back request; held until req_resp.
- req_addr  input  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_CH*LINE_W  packed write lines; channel i at [i*LINE_W +: LINE_W].
- req_resp  output  NUM_CH  one-hot completion strobe to the granted channel.
- req_rdata  output  LINE_W  read line, broadcast to all channels.
- pmem_read  output  1  physical read strobe.
- pmem_write  output  1  physical write strobe.
- pmem_address  output  ADDR_W  latched address.
- pmem_wdata  output  LINE_W  latched write line.
- pmem_resp  input  1  physical memory done, one-cycle pulse.
- pmem_rdata  input  LINE_W  physical read data, valid with pmem_resp.
- grant_id  output  $clog2(NUM_CH)  index of the current/last granted channel.
- busy  output  1  high in BUSY and RELEASE.

Behaviour:
- States: IDLE, BUSY, RELEASE.

Reset (rst_n low, asynchronous, any state):
- state = IDLE; pmem_read = pmem_write = 0; pmem_address = 0; pmem_wdata = 0; busy = 0; grant_id = 0.
- Round-robin pointer last = NUM_CH-1, so channel 0 is first in RR mode.
- req_resp = 0 by construction.
- Reset during BUSY abandons the transaction; a pmem_resp arriving afterwards in IDLE is ignored.

Channel request:
- req_i = req_read[i] | req_write[i].
- If both are set, the transaction is a write; the read is ignored for that grant.

IDLE -> BUSY, when any req_i is set:
- Fixed mode: winner = lowest set index.
- RR mode: winner = first set index searching last+1, last+2, ... modulo NUM_CH.
- At the same edge, register grant_id = winner and last = winner.
- Register pmem_address and pmem_wdata from the winner's slices.
- Register pmem_write = req_write[winner] and pmem_read = ~req_write[winner].
- Latency: a request sampled at edge k drives the pmem strobe from cycle k+1.
- No request: stay in IDLE, strobes 0.

BUSY:
- Strobes, address and wdata are held constant from the latched values.
- Later changes or withdrawal of the granted channel's inputs have no effect.
- On pmem_resp = 1:
  - req_resp[grant_id] = 1 combinationally in that same cycle; all other bits 0.
  - req_rdata = pmem_rdata.
  - At the edge, clear both strobes and go to RELEASE.

RELEASE:
- One dead cycle: strobes 0, req_resp 0, no arbitration.
- This lets the completed cache drop its request before re-arbitration.
- Then go to IDLE unconditionally.

Response routing:
- req_resp is 0 in IDLE and RELEASE regardless of pmem_resp.
- req_rdata = pmem_rdata continuously, pure pass-through; consumers qualify it with req_resp.

Throughput:
- Back-to-back transactions cost 2 overhead cycles: the grant cycle and RELEASE.

Starvation:
- RR mode guarantees each requester is served within NUM_CH grants.
- Fixed mode gives no such guarantee.

Simultaneous events:
- A new request arriving in the same cycle as pmem_resp is not granted until the following IDLE.
- RR fairness is preserved across this boundary.

Test Plan:
- Fixed mode, NUM_CH=2, req_read = 2'b11, addrs 0x1230/0x4560 -> grant_id=0, pmem_read=1 and pmem_address=0x1230 from cycle 1. On pmem_resp with pmem_rdata=0xA5..A5, req_resp=2'b01 that cycle. RELEASE, then channel 1 is granted with 0x4560.
- RR mode, NUM_CH=4, all four requests held continuously; memory responds 3 cycles after each strobe -> grant order 0,1,2,3,0. Each grant lasts exactly 4 busy cycles plus RELEASE.
- Write path: req_write[1]=1, addr 0x0080, wdata 0xDEAD...BEEF -> pmem_write=1 and pmem_read=0 with the latched values. Changing req_wdata mid-BUSY leaves pmem_wdata unchanged.
- Read and write both set on channel 0 -> only pmem_write asserted, single req_resp[0] pulse.
- Assert rst_n=0 mid-BUSY, then deliver pmem_resp while in IDLE -> all outputs 0 immediately, no req_resp pulse. Next grant in RR mode is channel 0.
- pmem_resp pulsed while in IDLE with no request -> req_resp stays 0 and state stays IDLE.
